// File: rtl/acc_framer.sv
// Store-and-forward framer: buffers whole frames, then emits len followed by exactly len bytes.
// Optional frame/byte statistics outputs are enabled by defining ACC_FRAMER_STATS_EN.
module acc_framer #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LDEPTH  = 4,
    parameter int unsigned MAX_LEN = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_en,
    output logic        in_rdy,
    output logic [7:0]  len_value,
    output logic        len_en,
    input  logic        len_rdy,
    output logic [7:0]  din_value,
    output logic        din_en,
    input  logic        din_rdy
`ifdef ACC_FRAMER_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [31:0] byte_cnt
`endif
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LAW = $clog2(LDEPTH);

    typedef enum logic [1:0] {StIdle, StLen, StData} state_e;

    state_e          state_q, state_d;
    logic [7:0]      rem_q, rem_d;
    logic [7:0]      part_q;

    logic [7:0]      dmem [DEPTH];
    logic [AW-1:0]   dwptr_q, drptr_q;
    logic [AW:0]     dcnt_q;

    logic [7:0]      lmem [LDEPTH];
    logic [LAW-1:0]  lwptr_q, lrptr_q;
    logic [LAW:0]    lcnt_q;

    logic            accept, close;
    logic            dfull, lfull;

    assign dfull  = (dcnt_q == (AW + 1)'(DEPTH));
    assign lfull  = (lcnt_q == (LAW + 1)'(LDEPTH));
    assign in_rdy = RST_N & !dfull & !lfull;
    assign accept = in_en & in_rdy;
    // Auto-close at MAX_LEN regardless of in_last, so no frame can exceed the length field.
    assign close  = accept & (in_last | ((part_q + 8'd1) == 8'(MAX_LEN)));

    always_ff @(posedge CLK) begin
        if (accept) dmem[dwptr_q] <= in_data;
        if (close) lmem[lwptr_q] <= part_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dwptr_q <= '0;
            drptr_q <= '0;
            dcnt_q  <= '0;
            lwptr_q <= '0;
            lrptr_q <= '0;
            lcnt_q  <= '0;
            part_q  <= '0;
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (accept) begin
                dwptr_q <= dwptr_q + 1'b1;
                part_q  <= close ? 8'd0 : part_q + 8'd1;
            end
            if (din_en) drptr_q <= drptr_q + 1'b1;
            case ({accept, din_en})
                2'b10:   dcnt_q <= dcnt_q + 1'b1;
                2'b01:   dcnt_q <= dcnt_q - 1'b1;
                default: ;
            endcase
            if (close) lwptr_q <= lwptr_q + 1'b1;
            if (len_en) lrptr_q <= lrptr_q + 1'b1;
            case ({close, len_en})
                2'b10:   lcnt_q <= lcnt_q + 1'b1;
                2'b01:   lcnt_q <= lcnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        len_en    = 1'b0;
        din_en    = 1'b0;
        len_value = 8'd0;
        din_value = 8'd0;
        case (state_q)
            StIdle: begin
                if (lcnt_q != '0) state_d = StLen;
            end
            StLen: begin
                len_value = lmem[lrptr_q];
                len_en    = len_rdy & RST_N;
                if (len_en) begin
                    rem_d   = lmem[lrptr_q];
                    state_d = StData;
                end
            end
            StData: begin
                // Whole frame is already buffered, so the data FIFO cannot run dry here.
                din_value = dmem[drptr_q];
                din_en    = din_rdy & RST_N;
                if (din_en) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = (lcnt_q != '0) ? StLen : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef ACC_FRAMER_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
        end else begin
            if (len_en) frame_cnt <= frame_cnt + 16'd1;
            if (din_en) byte_cnt <= byte_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_acc_framer.sv
// Directed self-checking bench for acc_framer; define ACC_FRAMER_STATS_EN to also check statistics.
module tb_acc_framer;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  in_data;
    logic        in_last, in_en, in_rdy;
    logic [7:0]  len_value;
    logic        len_en, len_rdy;
    logic [7:0]  din_value;
    logic        din_en, din_rdy;
`ifdef ACC_FRAMER_STATS_EN
    logic [15:0] frame_cnt;
    logic [31:0] byte_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_viol = 0;
    logic [7:0] len_log[$];
    logic [7:0] din_log[$];
    int len_cyc[$];
    int din_cyc[$];

    acc_framer #(.DEPTH(256), .LDEPTH(4), .MAX_LEN(255)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_en     (in_en),
        .in_rdy    (in_rdy),
        .len_value (len_value),
        .len_en    (len_en),
        .len_rdy   (len_rdy),
        .din_value (din_value),
        .din_en    (din_en),
        .din_rdy   (din_rdy)
`ifdef ACC_FRAMER_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .byte_cnt  (byte_cnt)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Transfers are logged mid-cycle; inputs only change just after the rising edge.
    always @(negedge CLK) begin
        if (len_en) begin
            len_log.push_back(len_value);
            len_cyc.push_back(cyc);
            if (!len_rdy) en_viol++;
        end
        if (din_en) begin
            din_log.push_back(din_value);
            din_cyc.push_back(cyc);
            if (!din_rdy) en_viol++;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic void clear_logs();
        len_log.delete();
        din_log.delete();
        len_cyc.delete();
        din_cyc.delete();
        en_viol = 0;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l, output logic ok);
        logic rdy;
        in_data = d;
        in_last = l;
        in_en   = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            rdy = in_rdy;
            @(posedge CLK);
            #1;
            ok = rdy;
        end
        in_en   = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_din(input int n, input int bound);
        for (int i = 0; i < bound && din_log.size() < n; i++) step();
    endtask

    task automatic test_reset();
        RST_N = 1'b0; in_en = 1'b0; in_last = 1'b0; in_data = 8'd0;
        len_rdy = 1'b1; din_rdy = 1'b1;
        step();
        step();
        @(negedge CLK);
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy: got %b expected 0", in_rdy); end
        checks++; if (len_en !== 1'b0) begin failures++; $display("FAIL reset_len_en: got %b expected 0", len_en); end
        checks++; if (din_en !== 1'b0) begin failures++; $display("FAIL reset_din_en: got %b expected 0", din_en); end
        checks++; if (len_value !== 8'd0) begin failures++; $display("FAIL reset_len_value: got %h expected 00", len_value); end
        checks++; if (din_value !== 8'd0) begin failures++; $display("FAIL reset_din_value: got %h expected 00", din_value); end
`ifdef ACC_FRAMER_STATS_EN
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (byte_cnt !== 32'd0) begin failures++; $display("FAIL reset_byte_cnt: got %0d expected 0", byte_cnt); end
`endif
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL release_in_rdy: got %b expected 1", in_rdy); end
        @(posedge CLK);
        #1;
        clear_logs();
    endtask

    task automatic test_single_frame();
        logic ok;
        int nsent = 0;
        int c0;
        clear_logs();
        len_rdy = 1'b1; din_rdy = 1'b1;
        send_byte(8'h01, 1'b0, ok); nsent += int'(ok);
        send_byte(8'h02, 1'b0, ok); nsent += int'(ok);
        send_byte(8'h03, 1'b1, ok); nsent += int'(ok);
        c0 = cyc;
        wait_din(3, 30);
        step(); step();
        checks++; if (nsent != 3) begin failures++; $display("FAIL single_accept: got %0d expected 3", nsent); end
        checks++; if (len_log.size() != 1) begin failures++; $display("FAIL single_len_count: got %0d expected 1", len_log.size()); end
        checks++; if (len_log.size() < 1 || len_log[0] !== 8'd3) begin failures++; $display("FAIL single_len_value: got %h expected 03", len_log[0]); end
        checks++; if (len_cyc.size() < 1 || len_cyc[0] != c0 + 1) begin failures++; $display("FAIL single_len_latency: got %0d expected %0d", len_cyc[0], c0 + 1); end
        checks++; if (din_log.size() != 3) begin failures++; $display("FAIL single_din_count: got %0d expected 3", din_log.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= din_log.size() || din_log[i] !== 8'(i + 1) || din_cyc[i] != c0 + 2 + i) begin
                failures++;
                $display("FAIL single_din[%0d]: got %h@%0d expected %h@%0d", i, din_log[i], din_cyc[i], i + 1, c0 + 2 + i);
            end
        end
    endtask

    task automatic test_auto_close();
        logic ok;
        int nsent = 0;
        int c_close;
        clear_logs();
        len_rdy = 1'b1; din_rdy = 1'b1;
        for (int i = 0; i < 255; i++) begin
            send_byte(8'(i), 1'b0, ok);
            nsent += int'(ok);
        end
        c_close = cyc;
        send_byte(8'hAA, 1'b1, ok); nsent += int'(ok);
        wait_din(256, 800);
        step(); step();
        checks++; if (nsent != 256) begin failures++; $display("FAIL auto_accept: got %0d expected 256", nsent); end
        checks++; if (len_log.size() != 2) begin failures++; $display("FAIL auto_len_count: got %0d expected 2", len_log.size()); end
        checks++; if (len_log.size() < 1 || len_log[0] !== 8'd255) begin failures++; $display("FAIL auto_len_value: got %0d expected 255", len_log[0]); end
        checks++; if (len_cyc.size() < 1 || len_cyc[0] != c_close + 1) begin failures++; $display("FAIL auto_len_latency: got %0d expected %0d", len_cyc[0], c_close + 1); end
        checks++; if (len_log.size() < 2 || len_log[1] !== 8'd1) begin failures++; $display("FAIL auto_next_len: got %0d expected 1", len_log[1]); end
        checks++; if (din_log.size() != 256) begin failures++; $display("FAIL auto_din_count: got %0d expected 256", din_log.size()); end
        for (int i = 0; i < 255; i++) begin
            checks++;
            if (i >= din_log.size() || din_log[i] !== 8'(i)) begin
                failures++;
                $display("FAIL auto_din[%0d]: got %h expected %h", i, din_log[i], 8'(i));
            end
        end
        checks++; if (din_log.size() < 256 || din_log[255] !== 8'hAA) begin failures++; $display("FAIL auto_next_din: got %h expected aa", din_log[255]); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        int nsent = 0;
        logic [7:0] exp_d [6];
        exp_d = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23};
        clear_logs();
        len_rdy = 1'b1; din_rdy = 1'b0;
        send_byte(8'h10, 1'b0, ok); nsent += int'(ok);
        send_byte(8'h11, 1'b1, ok); nsent += int'(ok);
        send_byte(8'h20, 1'b0, ok); nsent += int'(ok);
        send_byte(8'h21, 1'b0, ok); nsent += int'(ok);
        send_byte(8'h22, 1'b0, ok); nsent += int'(ok);
        send_byte(8'h23, 1'b1, ok); nsent += int'(ok);
        for (int i = 0; i < 100 && din_log.size() < 6; i++) begin
            din_rdy = ~din_rdy;
            step();
        end
        din_rdy = 1'b1;
        step(); step();
        checks++; if (nsent != 6) begin failures++; $display("FAIL b2b_accept: got %0d expected 6", nsent); end
        checks++; if (en_viol != 0) begin failures++; $display("FAIL b2b_en_without_rdy: got %0d expected 0", en_viol); end
        checks++; if (len_log.size() != 2 || len_log[0] !== 8'd2 || len_log[1] !== 8'd4) begin
            failures++; $display("FAIL b2b_lens: got %0d,%0d expected 2,4", len_log[0], len_log[1]);
        end
        checks++; if (din_log.size() != 6) begin failures++; $display("FAIL b2b_din_count: got %0d expected 6", din_log.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= din_log.size() || din_log[i] !== exp_d[i]) begin
                failures++; $display("FAIL b2b_din[%0d]: got %h expected %h", i, din_log[i], exp_d[i]);
            end
        end
        checks++;
        if (len_cyc.size() < 2 || din_cyc.size() < 3 || len_cyc[1] <= din_cyc[1] || len_cyc[1] >= din_cyc[2]) begin
            failures++; $display("FAIL b2b_len_order: got len2@%0d expected between %0d and %0d", len_cyc[1], din_cyc[1], din_cyc[2]);
        end
    endtask

    task automatic test_len_backpressure();
        logic ok;
        int nsent = 0;
        clear_logs();
        len_rdy = 1'b0; din_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h31 + i), 1'b1, ok);
            nsent += int'(ok);
        end
        @(negedge CLK);
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_three: got %b expected 1", in_rdy); end
        @(posedge CLK);
        #1;
        send_byte(8'h34, 1'b1, ok); nsent += int'(ok);
        @(negedge CLK);
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL bp_rdy_full: got %b expected 0", in_rdy); end
        @(posedge CLK);
        #1;
        in_data = 8'h99; in_last = 1'b1; in_en = 1'b1;
        repeat (4) step();
        in_en = 1'b0; in_last = 1'b0;
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL bp_rdy_held: got %b expected 0", in_rdy); end
        checks++; if (len_log.size() != 0) begin failures++; $display("FAIL bp_len_held: got %0d expected 0", len_log.size()); end
        len_rdy = 1'b1;
        wait_din(4, 40);
        repeat (5) step();
        checks++; if (nsent != 4) begin failures++; $display("FAIL bp_accept: got %0d expected 4", nsent); end
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_back: got %b expected 1", in_rdy); end
        checks++; if (len_log.size() != 4) begin failures++; $display("FAIL bp_len_count: got %0d expected 4", len_log.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= len_log.size() || len_log[i] !== 8'd1 || i >= din_log.size() || din_log[i] !== 8'(8'h31 + i)) begin
                failures++; $display("FAIL bp_frame[%0d]: got len %0d data %h expected len 1 data %h", i, len_log[i], din_log[i], 8'h31 + i);
            end
        end
        checks++; if (din_log.size() != 4) begin failures++; $display("FAIL bp_din_count: got %0d expected 4", din_log.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic ok;
        int nsent = 0;
        clear_logs();
        len_rdy = 1'b1; din_rdy = 1'b0;
        send_byte(8'h41, 1'b0, ok); nsent += int'(ok);
        send_byte(8'h42, 1'b0, ok); nsent += int'(ok);
        send_byte(8'h43, 1'b1, ok); nsent += int'(ok);
        for (int i = 0; i < 20 && len_log.size() < 1; i++) step();
        din_rdy = 1'b1;
        step();
        din_rdy = 1'b0;
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        din_rdy = 1'b1;
        @(negedge CLK);
        checks++; if (nsent != 3) begin failures++; $display("FAIL rst_mid_accept: got %0d expected 3", nsent); end
        checks++; if (len_en !== 1'b0 || din_en !== 1'b0) begin failures++; $display("FAIL rst_mid_en: got len_en=%b din_en=%b expected 0,0", len_en, din_en); end
        checks++; if (din_log.size() != 1 || din_log[0] !== 8'h41) begin failures++; $display("FAIL rst_mid_sent: got %0d bytes first %h expected 1 byte 41", din_log.size(), din_log[0]); end
        @(posedge CLK);
        #1;
        clear_logs();
        repeat (10) step();
        checks++; if (len_log.size() != 0 || din_log.size() != 0) begin failures++; $display("FAIL rst_mid_quiet: got %0d len %0d din expected 0,0", len_log.size(), din_log.size()); end
        send_byte(8'h55, 1'b1, ok);
        wait_din(1, 20);
        repeat (5) step();
        checks++; if (!ok || len_log.size() != 1 || len_log[0] !== 8'd1) begin failures++; $display("FAIL rst_mid_new_len: got %0d entries first %0d expected 1 entry 1", len_log.size(), len_log[0]); end
        checks++; if (din_log.size() != 1 || din_log[0] !== 8'h55) begin failures++; $display("FAIL rst_mid_new_din: got %0d bytes first %h expected 1 byte 55", din_log.size(), din_log[0]); end
    endtask

`ifdef ACC_FRAMER_STATS_EN
    task automatic test_stats();
        logic ok;
        int nsent = 0;
        int lens [3];
        lens = '{2, 3, 5};
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        clear_logs();
        len_rdy = 1'b1; din_rdy = 1'b1;
        checks++; if (frame_cnt !== 16'd0 || byte_cnt !== 32'd0) begin failures++; $display("FAIL stats_start: got %0d,%0d expected 0,0", frame_cnt, byte_cnt); end
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < lens[f]; b++) begin
                send_byte(8'(8'h60 + b), b == lens[f] - 1, ok);
                nsent += int'(ok);
            end
        end
        wait_din(10, 60);
        repeat (3) step();
        checks++; if (nsent != 10) begin failures++; $display("FAIL stats_accept: got %0d expected 10", nsent); end
        checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL stats_frame_cnt: got %0d expected 3", frame_cnt); end
        checks++; if (byte_cnt !== 32'd10) begin failures++; $display("FAIL stats_byte_cnt: got %0d expected 10", byte_cnt); end
        RST_N = 1'b0;
        step();
        @(negedge CLK);
        checks++; if (frame_cnt !== 16'd0 || byte_cnt !== 32'd0) begin failures++; $display("FAIL stats_reset: got %0d,%0d expected 0,0", frame_cnt, byte_cnt); end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_auto_close();
        test_back_to_back();
        test_len_backpressure();
        test_reset_mid_frame();
`ifdef ACC_FRAMER_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
